// File: rtl/bist_pkg.sv
// Shared definitions for the BIST output-response analyser: FSM state codes
// and the 16-bit MISR step function (x^16 + x^14 + x^13 + x^11 + 1).
package bist_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_SEED     = 3'd1;
   localparam logic [2:0] ST_COMPRESS = 3'd2;
   localparam logic [2:0] ST_COMPARE  = 3'd3;
   localparam logic [2:0] ST_DONE     = 3'd4;

   // Tap positions 15, 13, 12 and 10 of the signature register.
   localparam logic [15:0] MISR_TAPS = 16'hB400;

   function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                             input logic [15:0] data);
      logic fb;
      fb = ^(sig & MISR_TAPS);
      return {sig[14:0], fb} ^ data;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// 16-bit multiple-input signature register: seed load has priority over compress.
// One-cycle update latency; no flow control, the caller gates compression with en_i.
module bist_misr
   import bist_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] SEED  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] data_i,
   output logic [WIDTH-1:0] sig_o
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load_i) begin
         sig_d = SEED;
      end else if (en_i) begin
         sig_d = misr_next(sig_q, data_i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig_o = sig_q;

endmodule

// File: rtl/bist_signature_analyzer.sv
// Compresses a counted run of patterns into a MISR signature and grades it against a golden value.
// Result visible two edges after the final valid pattern; pattern_valid=0 simply stalls the run.
module bist_signature_analyzer
   import bist_pkg::*;
#(
   parameter int               WIDTH = 16,
   parameter int               CNT_W = 10,
   parameter logic [WIDTH-1:0] SEED  = 16'h0000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             pattern_valid,
   input  logic [WIDTH-1:0] pattern,
   input  logic [CNT_W-1:0] test_length,
   input  logic [WIDTH-1:0] golden,
   output logic [WIDTH-1:0] signature,
   output logic [CNT_W-1:0] pattern_count,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             fail
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic [WIDTH-1:0] gold_q, gold_d;
   logic             pass_q, pass_d;
   logic             fail_q, fail_d;
   logic             misr_load;
   logic             misr_en;
   logic             sig_match;

   assign sig_match = (signature == gold_q);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      len_d     = len_q;
      gold_d    = gold_q;
      pass_d    = pass_q;
      fail_d    = fail_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      // Abort wins over everything; signature and count are left for debug.
      if (abort) begin
         state_d = ST_IDLE;
         pass_d  = 1'b0;
         fail_d  = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_SEED;
                  len_d   = test_length;
                  gold_d  = golden;
               end
            end
            ST_SEED: begin
               misr_load = 1'b1;
               cnt_d     = '0;
               state_d   = (len_q == '0) ? ST_COMPARE : ST_COMPRESS;
            end
            ST_COMPRESS: begin
               if (pattern_valid) begin
                  misr_en = 1'b1;
                  cnt_d   = cnt_q + CNT_ONE;
                  if (cnt_q == len_q - CNT_ONE) begin
                     state_d = ST_COMPARE;
                  end
               end
            end
            ST_COMPARE: begin
               pass_d  = sig_match;
               fail_d  = !sig_match;
               state_d = ST_DONE;
            end
            ST_DONE: begin
               if (start) begin
                  state_d = ST_SEED;
                  len_d   = test_length;
                  gold_d  = golden;
                  pass_d  = 1'b0;
                  fail_d  = 1'b0;
               end
            end
            default: begin
               state_d = ST_IDLE;
               pass_d  = 1'b0;
               fail_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         len_q   <= '0;
         gold_q  <= '0;
         pass_q  <= 1'b0;
         fail_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         gold_q  <= gold_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
      end
   end

   bist_misr #(
      .WIDTH (WIDTH),
      .SEED  (SEED)
   ) u_misr (
      .clk    (clk),
      .rst    (rst),
      .load_i (misr_load),
      .en_i   (misr_en),
      .data_i (pattern),
      .sig_o  (signature)
   );

   assign pattern_count = cnt_q;
   assign busy          = (state_q == ST_SEED) || (state_q == ST_COMPRESS) ||
                          (state_q == ST_COMPARE);
   assign done          = (state_q == ST_DONE);
   assign pass          = pass_q;
   assign fail          = fail_q;

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed-vector bench for bist_signature_analyzer with hand-computed signatures.
module tb_bist_signature_analyzer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        abort;
   logic        pattern_valid;
   logic [15:0] pattern;
   logic [9:0]  test_length;
   logic [15:0] golden;
   logic [15:0] signature;
   logic [9:0]  pattern_count;
   logic        busy;
   logic        done;
   logic        pass;
   logic        fail;

   int checks = 0;
   int errors = 0;

   bist_signature_analyzer #(
      .WIDTH (16),
      .CNT_W (10),
      .SEED  (16'h0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .abort         (abort),
      .pattern_valid (pattern_valid),
      .pattern       (pattern),
      .test_length   (test_length),
      .golden        (golden),
      .signature     (signature),
      .pattern_count (pattern_count),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .fail          (fail)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [9:0] len, input logic [15:0] gold);
      start       = 1'b1;
      test_length = len;
      golden      = gold;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input logic [15:0] p);
      pattern_valid = 1'b1;
      pattern       = p;
      tick();
      pattern_valid = 1'b0;
      pattern       = 16'hFFFF;
   endtask

   task automatic chk_flags(input string tag, input logic [3:0] exp_bdpf);
      chk(tag, {28'd0, busy, done, pass, fail}, {28'd0, exp_bdpf});
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; abort = 1'b0; pattern_valid = 1'b0;
      pattern = 16'h0; test_length = 10'd0; golden = 16'h0;
      tick();
      tick();
      chk("reset_sig", {16'd0, signature}, 32'h0);
      chk("reset_cnt", {22'd0, pattern_count}, 32'd0);
      chk_flags("reset_flags", 4'b0000);
      rst = 1'b1;
      tick();
      chk_flags("idle_flags", 4'b0000);

      // Two patterns of 0001: signature 0001 then 0003, golden matches.
      do_start(10'd2, 16'h0003);
      chk_flags("t1_seed_busy", 4'b1000);
      tick();
      send(16'h0001);
      chk("t1_sig1", {16'd0, signature}, 32'h0001);
      chk("t1_cnt1", {22'd0, pattern_count}, 32'd1);
      send(16'h0001);
      chk("t1_sig2", {16'd0, signature}, 32'h0003);
      chk("t1_cnt2", {22'd0, pattern_count}, 32'd2);
      chk_flags("t1_compare", 4'b1000);
      tick();
      chk_flags("t1_done_pass", 4'b0110);

      // Wrong golden; golden input changed after start must not matter.
      do_start(10'd2, 16'h0004);
      golden = 16'h0003;
      chk_flags("t2_restart_clears", 4'b1000);
      tick();
      send(16'h0001);
      send(16'h0001);
      tick();
      chk_flags("t2_done_fail", 4'b0101);
      chk("t2_sig_hold", {16'd0, signature}, 32'h0003);

      do_start(10'd2, 16'h0003);
      chk_flags("t2b_done_drop", 4'b1000);
      tick();
      send(16'h0001);
      send(16'h0001);
      tick();
      chk_flags("t2b_pass", 4'b0110);

      // Zero-length run grades the seed directly.
      do_start(10'd0, 16'h0000);
      chk_flags("t3_seed", 4'b1000);
      tick();
      chk_flags("t3_compare", 4'b1000);
      tick();
      chk_flags("t3_pass", 4'b0110);
      chk("t3_cnt", {22'd0, pattern_count}, 32'd0);

      // B400 -> B400; 0000 -> 6800; 0010 -> D011 (feedback bit set on last step).
      do_start(10'd3, 16'hD011);
      pattern_valid = 1'b1;
      pattern       = 16'hFFFF;
      tick();
      pattern_valid = 1'b0;
      chk("t4_seed_ignores_valid_sig", {16'd0, signature}, 32'h0000);
      chk("t4_seed_ignores_valid_cnt", {22'd0, pattern_count}, 32'd0);
      send(16'hB400);
      chk("t4_sig1", {16'd0, signature}, 32'hB400);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("t4_gap_cnt", {22'd0, pattern_count}, 32'd1);
      chk("t4_gap_sig", {16'd0, signature}, 32'hB400);
      send(16'h0000);
      chk("t4_sig2", {16'd0, signature}, 32'h6800);
      chk("t4_cnt2", {22'd0, pattern_count}, 32'd2);
      for (int i = 0; i < 5; i++) tick();
      chk("t4_gap5_cnt", {22'd0, pattern_count}, 32'd2);
      send(16'h0010);
      chk("t4_sig3", {16'd0, signature}, 32'hD011);
      chk("t4_cnt3", {22'd0, pattern_count}, 32'd3);
      chk_flags("t4_edge1_not_done", 4'b1000);
      tick();
      chk_flags("t4_edge2_done_pass", 4'b0110);

      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk_flags("t4_abort_from_done", 4'b0000);
      chk("t4_abort_sig_hold", {16'd0, signature}, 32'hD011);

      // Abort mid-compress, with a simultaneous start that must lose.
      do_start(10'd4, 16'h0000);
      tick();
      send(16'h0001);
      chk("t5_sig1", {16'd0, signature}, 32'h0001);
      abort = 1'b1;
      start = 1'b1;
      tick();
      abort = 1'b0;
      start = 1'b0;
      chk_flags("t5_abort_idle", 4'b0000);
      chk("t5_abort_sig", {16'd0, signature}, 32'h0001);
      chk("t5_abort_cnt", {22'd0, pattern_count}, 32'd1);
      tick();
      chk_flags("t5_stays_idle", 4'b0000);
      do_start(10'd3, 16'h0000);
      tick();
      chk("t5_reseed_sig", {16'd0, signature}, 32'h0000);
      chk("t5_reseed_cnt", {22'd0, pattern_count}, 32'd0);
      chk_flags("t5_reseed_busy", 4'b1000);

      // Asynchronous reset mid-run, checked before the next clock edge.
      send(16'h1234);
      chk("t6_sig_pre", {16'd0, signature}, 32'h1234);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_sig", {16'd0, signature}, 32'h0);
      chk("t6_async_cnt", {22'd0, pattern_count}, 32'd0);
      chk_flags("t6_async_flags", 4'b0000);
      tick();
      rst = 1'b1;
      tick();
      chk_flags("t6_after_reset", 4'b0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
